// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned IMEM_ADDR_BITS = 7;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Word index the instruction memory decodes from a byte address.
  function automatic logic [IMEM_ADDR_BITS-1:0] imem_word_index(input logic [XLEN-1:0] addr);
    return addr[IMEM_ADDR_BITS+1:2];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: byte address out, instruction word back combinationally.
interface instruction_fetch_unit_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] ImemAddress;
  logic [XLEN-1:0] ImemInstruction;

  modport master (output ImemAddress, input ImemInstruction);
  modport slave  (input ImemAddress, output ImemInstruction);
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter register with synchronous reset and load enable.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VALUE = RESET_PC_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            load,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= RESET_VALUE;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP      = NOP_WORD
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  BranchTaken,
  input  logic [XLEN-1:0]       BranchTarget,
  input  logic                  Halt,
  instruction_fetch_unit_if.master imem,
  output logic [XLEN-1:0]       IFID_Instruction,
  output logic [XLEN-1:0]       IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic [XLEN-1:0]       PC,
  output logic                  Halted,
  output logic                  MisalignFault
);

  localparam ifid_t BUBBLE = '{instruction: NOP, pc_plus4: '0, valid: 1'b0};

  fetch_state_e    state_q;
  fetch_state_e    state_next;
  ifid_t           ifid_q;
  ifid_t           ifid_next;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign_set;

  pc_register #(.RESET_VALUE(RESET_PC)) u_pc (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (pc_load),
    .next_pc (pc_next),
    .pc      (PC)
  );

  assign imem.ImemAddress = PC;
  assign pc_plus4         = PC + XLEN'(4);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_next;
    end
  end

  // Priority in RUN: Halt > BranchTaken > Flush > Stall > sequential fetch.
  always_comb begin
    state_next   = state_q;
    ifid_next    = ifid_q;
    pc_load      = 1'b0;
    pc_next      = PC;
    misalign_set = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_next = Halt ? HALTED : RUN;
      end
      RUN: begin
        if (Halt) begin
          state_next = HALTED;
          ifid_next  = BUBBLE;
        end else if (BranchTaken) begin
          pc_load      = 1'b1;
          pc_next      = {BranchTarget[XLEN-1:2], 2'b00};
          ifid_next    = BUBBLE;
          misalign_set = |BranchTarget[1:0];
        end else if (Flush) begin
          ifid_next = BUBBLE;
        end else if (!Stall) begin
          pc_load   = 1'b1;
          pc_next   = pc_plus4;
          ifid_next = '{instruction: imem.ImemInstruction, pc_plus4: pc_plus4, valid: 1'b1};
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = BOOT;
        ifid_next  = BUBBLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ifid_q        <= BUBBLE;
      Halted        <= 1'b0;
      MisalignFault <= 1'b0;
    end else begin
      ifid_q <= ifid_next;
      Halted <= (state_next == HALTED);
      if (misalign_set) begin
        MisalignFault <= 1'b1;
      end
    end
  end

  assign IFID_Instruction = ifid_q.instruction;
  assign IFID_PCPlus4     = ifid_q.pc_plus4;
  assign IFID_Valid       = ifid_q.valid;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface. Owns the program counter and drives the byte address into the 128-word instruction memory.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump redirect, pipeline stall and flush, and halt.
- Sits between the hazard/branch logic in EX/ID and the instruction memory. The memory read is combinational, so a fetch completes within the cycle.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_ADDR_BITS, 7, word-index width of the instruction memory; the memory uses address bits [IMEM_ADDR_BITS+1:2].
- NOP_WORD, 32'h00000000, bubble instruction inserted into IF/ID.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- Flush  in  1  squash the instruction being fetched this cycle.
- BranchTaken  in  1  redirect request from branch/jump resolution.
- BranchTarget  in  32  redirect byte address.
- Halt  in  1  stop fetching (end of program).
- ImemAddress  out  32  byte address to instruction memory; equals PC.
- ImemInstruction  in  32  instruction word returned combinationally by memory.
- IFID_Instruction  out  32  registered instruction to decode.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction.
- PC  out  32  current program counter (debug/display).
- Halted  out  1  fetch unit is in HALTED.
- MisalignFault  out  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (synchronous, highest priority): PC=RESET_PC, state=BOOT, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, MisalignFault=0. Reset asserted mid-operation discards all in-flight state the same cycle.
- ImemAddress = PC, combinational. The memory ignores bits [1:0] and bits above IMEM_ADDR_BITS+1. A PC of 0x200 therefore aliases word 0. This is intended; there is no trap.
- States: BOOT, RUN, HALTED.
  - BOOT: lasts exactly one cycle after reset. IF/ID keeps the bubble and PC holds. Next state is RUN unless Halt=1, which goes to HALTED.
  - RUN: per-cycle priority is Halt > BranchTaken > Flush > Stall > normal.
    - Normal: IFID_Instruction<=ImemInstruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, PC<=PC+4. Fetch-to-IF/ID latency is 1 cycle.
    - Stall: PC and all IF/ID outputs hold their values.
    - Flush without branch: IF/ID <= bubble (NOP_WORD, PCPlus4=0, Valid=0); PC holds.
    - BranchTaken: PC<={BranchTarget[31:2],2'b00}; IF/ID <= bubble. BranchTaken overrides a simultaneous Stall or Flush. If BranchTarget[1:0]!=0, MisalignFault<=1 (sticky until Reset).
    - Halt: next state HALTED; IF/ID <= bubble; PC holds.
  - HALTED: Halted=1. PC frozen, IF/ID held at bubble. All inputs except Reset are ignored; the only exit is Reset.
- Arithmetic: PC+4 is 32-bit unsigned and wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000) with no flag.
- IFID_PCPlus4 carries the value before wrap-around masking by the memory, i.e. the full 32-bit PC+4.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2);
  - NOP_WORD constant;
  - default RESET_PC;
  - IMEM_ADDR_BITS.
- One sub-module, pc_register: a 32-bit PC register with synchronous reset, load-enable and next-value input. The next-PC mux and IF/ID register live in instruction_fetch_unit.

Test Plan:
- Reset, release, memory model where memory[i]=i*3 → BOOT cycle: IFID_Valid=0, PC=0. Next cycle: IFID_Instruction=0, PCPlus4=4. Following cycle: IFID_Instruction=3, PC=8.
- Stall high for 3 cycles at PC=0x10 → PC stays 0x10, IF/ID holds word 3 (value 9) for all 3 cycles. After release, word 4 (value 12) is captured.
- BranchTaken=1 with BranchTarget=0x40, with Stall=1 in the same cycle → next PC=0x40, IFID_Valid=0. The next cycle captures memory[16]=48.
- BranchTarget=0x42 → PC=0x40 and MisalignFault=1; the flag stays 1 until Reset.
- Halt at PC=0x20 → Halted=1, PC frozen at 0x20, IFID_Valid=0. BranchTaken is then ignored. Reset returns to PC=0, Halted=0.
- PC forced near the top via BranchTarget=0xFFFFFFFC → next PC=0x00000000, IFID_PCPlus4=0x00000000. Separately, PC=0x200 reads memory[0].
